// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one word read/write at a time with a fixed
// response latency, flagging misaligned or out-of-range accesses instead of performing them.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 128,
   parameter int LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        ready_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          we_q;
   logic          err_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          req_err;
   logic [AW-1:0] req_idx;
   logic          sel_err;
   logic          sel_we;
   logic [AW-1:0] sel_idx;
   logic [31:0]   sel_wdata;
   logic [31:0]   resp_data;

   assign req_err = (addr_i[1:0] != 2'b00) || (addr_i[31:2] >= 30'(DEPTH_WORDS));
   assign req_idx = addr_i[AW+1:2];

   // With LATENCY=1 the response is formed on the accepting edge, so it must
   // come straight from the request inputs rather than the latched copies.
   always_comb begin
      sel_err   = err_q;
      sel_we    = we_q;
      sel_idx   = idx_q;
      sel_wdata = wdata_q;
      if (state == IDLE) begin
         sel_err   = req_err;
         sel_we    = we_i;
         sel_idx   = req_idx;
         sel_wdata = wdata_i;
      end
      if (sel_err)
         resp_data = '0;
      else if (sel_we)
         resp_data = sel_wdata;
      else
         resp_data = mem[sel_idx];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         busy_o  <= 1'b0;
         ready_o <= 1'b0;
         err_o   <= 1'b0;
         rdata_o <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         for (int i = 0; i < DEPTH_WORDS; i++)
            mem[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_i) begin
                  we_q    <= we_i;
                  err_q   <= req_err;
                  idx_q   <= req_idx;
                  wdata_q <= wdata_i;
                  cnt     <= 4'(LATENCY - 1);
                  busy_o  <= 1'b1;
                  if (LATENCY == 1) begin
                     state   <= RESP;
                     ready_o <= 1'b1;
                     err_o   <= sel_err;
                     rdata_o <= resp_data;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state   <= RESP;
                  cnt     <= '0;
                  ready_o <= 1'b1;
                  err_o   <= sel_err;
                  rdata_o <= resp_data;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               // Writes commit only as the response completes, so a reset during
               // the transaction discards them.
               if (we_q && !err_q)
                  mem[idx_q] <= wdata_q;
               state   <= IDLE;
               busy_o  <= 1'b0;
               ready_o <= 1'b0;
               err_o   <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               busy_o  <= 1'b0;
               ready_o <= 1'b0;
               err_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule
